vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480 VGA timing generator with registered DAC outputs
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] color_in_332,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       display_enable,
  output logic       frame_start,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       r_p;
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank_n;
  logic [7:0] r_r;
  logic [7:0] r_g;
  logic [7:0] r_b;

  logic       w_de;
  logic       w_hs_n;
  logic       w_vs_n;
  logic [2:0] w_r3;
  logic [2:0] w_g3;
  logic [1:0] w_b2;

  assign w_de   = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_n = !((r_h >= HS_BEG) && (r_h < HS_END));
  assign w_vs_n = !((r_v >= VS_BEG) && (r_v < VS_END));
  assign w_r3   = color_in_332[7:5];
  assign w_g3   = color_in_332[4:2];
  assign w_b2   = color_in_332[1:0];

  // Everything advances on the p=1 edge, which is also where vga_clk falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p       <= 1'b0;
      r_h       <= '0;
      r_v       <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
    end else begin
      r_p <= ~r_p;
      if (r_p) begin
        if (r_h == H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == V_LAST) ? '0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
        r_hs      <= w_hs_n;
        r_vs      <= w_vs_n;
        r_blank_n <= w_de;
        r_r       <= w_de ? {w_r3, w_r3, w_r3[2:1]} : 8'd0;
        r_g       <= w_de ? {w_g3, w_g3, w_g3[2:1]} : 8'd0;
        r_b       <= w_de ? {w_b2, w_b2, w_b2, w_b2} : 8'd0;
      end
    end
  end

  assign pixel_x        = r_h;
  assign pixel_y        = r_v;
  assign display_enable = w_de;
  assign frame_start    = r_p && (r_h == 10'd0) && (r_v == 10'd0);
  assign vga_clk        = r_p;
  assign vga_hs         = r_hs;
  assign vga_vs         = r_vs;
  assign vga_blank_n    = r_blank_n;
  assign vga_sync_n     = 1'b0;
  assign vga_r          = r_r;
  assign vga_g          = r_g;
  assign vga_b          = r_b;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (full-size and reduced geometry)
module tb_vga_timing_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] color;

  logic [9:0] b_x, b_y, s_x, s_y;
  logic       b_de, b_fs, b_vclk, b_hs, b_vs, b_bl, b_sync;
  logic       s_de, s_fs, s_vclk, s_hs, s_vs, s_bl, s_sync;
  logic [7:0] b_r, b_g, b_b, s_r, s_g, s_b;

  always #10 clk = ~clk;

  vga_timing_gen u_big (
    .clk(clk), .rst(rst), .color_in_332(color),
    .pixel_x(b_x), .pixel_y(b_y), .display_enable(b_de), .frame_start(b_fs),
    .vga_clk(b_vclk), .vga_hs(b_hs), .vga_vs(b_vs), .vga_blank_n(b_bl),
    .vga_sync_n(b_sync), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk(clk), .rst(rst), .color_in_332(color),
    .pixel_x(s_x), .pixel_y(s_y), .display_enable(s_de), .frame_start(s_fs),
    .vga_clk(s_vclk), .vga_hs(s_hs), .vga_vs(s_vs), .vga_blank_n(s_bl),
    .vga_sync_n(s_sync), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
  );

  typedef struct { int ha, hf, hs, hb, va, vf, vs, vb; } geom_t;
  typedef struct {
    logic [9:0]  x, y;
    logic        de, fs, vclk, hs, vs, bl, sync;
    logic [23:0] rgb;
  } obs_t;
  typedef struct { logic [7:0] c; logic [23:0] rgb; } vec_t;

  geom_t      gb, gs;
  int         n;
  logic [7:0] c_s;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [23:0] expand(logic [7:0] c);
    int r3, g3, b2;
    r3 = int'(c[7:5]);
    g3 = int'(c[4:2]);
    b2 = int'(c[1:0]);
    return {8'((r3 << 5) | (r3 << 2) | (r3 >> 1)),
            8'((g3 << 5) | (g3 << 2) | (g3 >> 1)),
            8'(b2 * 85)};
  endfunction

  // n = clk edges since reset release; every second edge is a pixel step.
  function automatic obs_t model(geom_t gm, int cyc, logic [7:0] c);
    obs_t o;
    int ht, vt, m, q, hq, vq;
    ht = gm.ha + gm.hf + gm.hs + gm.hb;
    vt = gm.va + gm.vf + gm.vs + gm.vb;
    m  = cyc / 2;
    o.vclk = (cyc % 2) == 1;
    o.x    = 10'(m % ht);
    o.y    = 10'((m / ht) % vt);
    o.de   = (int'(o.x) < gm.ha) && (int'(o.y) < gm.va);
    o.fs   = o.vclk && ((m % (ht * vt)) == 0);
    o.sync = 1'b0;
    o.hs   = 1'b1;
    o.vs   = 1'b1;
    o.bl   = 1'b0;
    o.rgb  = '0;
    if (m > 0) begin
      q  = m - 1;
      hq = q % ht;
      vq = (q / ht) % vt;
      o.hs = !(hq >= gm.ha + gm.hf && hq < gm.ha + gm.hf + gm.hs);
      o.vs = !(vq >= gm.va + gm.vf && vq < gm.va + gm.vf + gm.vs);
      o.bl = (hq < gm.ha) && (vq < gm.va);
      if (o.bl) o.rgb = expand(c);
    end
    return o;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at n=%0d t=%0t", name, act, exp, n, $time);
    end
  endtask

  task automatic check_all();
    obs_t eb, es;
    eb = model(gb, n, c_s);
    es = model(gs, n, c_s);
    cmp("big_xy", 32'({b_x, b_y}), 32'({eb.x, eb.y}));
    cmp("big_ctl", 32'({b_de, b_fs, b_vclk, b_hs, b_vs, b_bl, b_sync}),
        32'({eb.de, eb.fs, eb.vclk, eb.hs, eb.vs, eb.bl, eb.sync}));
    cmp("big_rgb", 32'({b_r, b_g, b_b}), 32'(eb.rgb));
    cmp("small_xy", 32'({s_x, s_y}), 32'({es.x, es.y}));
    cmp("small_ctl", 32'({s_de, s_fs, s_vclk, s_hs, s_vs, s_bl, s_sync}),
        32'({es.de, es.fs, es.vclk, es.hs, es.vs, es.bl, es.sync}));
    cmp("small_rgb", 32'({s_r, s_g, s_b}), 32'(es.rgb));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (n % 2 == 1) c_s = color;
      n++;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int k);
    rst = 1'b1;
    n   = 0;
    #1;
    check_all();
    repeat (k) step();
    rst = 1'b0;
  endtask

  vec_t tbl[6];
  int   first_low, hs_low, bl_low, last_fs, fs_cnt, vs_low;

  initial begin
    gb = '{640, 16, 96, 48, 480, 10, 2, 33};
    gs = '{8, 2, 3, 2, 4, 1, 2, 1};
    tbl[0] = '{8'b00100101, 24'h242455};
    tbl[1] = '{8'hFF, 24'hFFFFFF};
    tbl[2] = '{8'h00, 24'h000000};
    tbl[3] = '{8'hE0, 24'hFF0000};
    tbl[4] = '{8'h1C, 24'h00FF00};
    tbl[5] = '{8'h8A, 24'h9249AA};

    rst   = 1'b1;
    color = 8'h00;
    c_s   = 8'h00;
    n     = 0;
    @(negedge clk);
    check_all();
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_reset(1);
      color = tbl[i].c;
      repeat (40) step();
      cmp("tbl_active_rgb", 32'({b_r, b_g, b_b}), 32'(tbl[i].rgb));
      repeat (1360) step();
      cmp("tbl_blank_rgb", 32'({b_r, b_g, b_b}), 32'h0);
    end

    do_reset(1);
    color     = 8'h5A;
    first_low = -1;
    hs_low    = 0;
    bl_low    = 0;
    for (int i = 0; i < 3200; i++) begin
      step();
      if (b_hs == 1'b0 && first_low < 0) first_low = n;
      if (n == 1599) cmp("y_before_wrap", 32'(b_y), 32'd0);
      if (n == 1600) cmp("y_at_wrap", 32'(b_y), 32'd1);
      if (n > 1600) begin
        if (!b_hs) hs_low++;
        if (!b_bl) bl_low++;
      end
    end
    cmp("hs_fall_clk", 32'(first_low), 32'd1314);
    cmp("hs_low_clks", 32'(hs_low), 32'd192);
    cmp("blank_low_clks", 32'(bl_low), 32'd320);

    do_reset(1);
    last_fs = -1;
    fs_cnt  = 0;
    vs_low  = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (s_fs) begin
        fs_cnt++;
        if (last_fs < 0) cmp("fs_first", 32'(n), 32'd1);
        else cmp("fs_period", 32'(n - last_fs), 32'd240);
        last_fs = n;
      end
      if (n > 240 && n <= 480 && !s_vs) vs_low++;
    end
    cmp("fs_count", 32'(fs_cnt), 32'd3);
    cmp("vs_low_clks", 32'(vs_low), 32'd60);

    do_reset(1);
    color = 8'hC3;
    repeat (600) step();
    cmp("pre_rst_x", 32'(b_x), 32'd300);
    rst = 1'b1;
    n   = 0;
    #1;
    cmp("async_rst_x", 32'(b_x), 32'd0);
    cmp("async_rst_ctl", 32'({b_de, b_fs, b_vclk, b_hs, b_vs, b_bl}), 32'b100110);
    check_all();
    repeat (3) step();
    rst = 1'b0;
    repeat (200) step();

    for (int i = 0; i < 20000; i++) begin
      color = 8'($urandom);
      if ($urandom_range(0, 2999) == 0) do_reset(int'($urandom_range(1, 3)));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
